// File: rtl/axil_regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : axil_regfile_pkg
//  Purpose  : Shared constants, state encodings and the byte-merge helper
//             used by the AXI-Lite control register file.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package axil_regfile_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // Write path: collecting AW/W, or holding a B response.
   typedef enum logic [0:0] {
      WR_IDLE = 1'b0,
      WR_RESP = 1'b1
   } wr_state_e;

   // Read path: accepting AR, or holding an R response.
   typedef enum logic [0:0] {
      RD_IDLE = 1'b0,
      RD_RESP = 1'b1
   } rd_state_e;

   // Merge wdata into old_word on the bytes whose strobe bit is set.
   function automatic logic [31:0] apply_wstrb(
      input logic [31:0] old_word,
      input logic [31:0] wdata,
      input logic [3:0]  wstrb
   );
      logic [31:0] merged;
      merged = old_word;
      for (int b = 0; b < 4; b++) begin
         if (wstrb[b]) begin
            merged[8*b +: 8] = wdata[8*b +: 8];
         end
      end
      return merged;
   endfunction

endpackage
`default_nettype wire

// File: rtl/axil_ctrl_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : axil_ctrl_regfile
//  Purpose  : AXI-Lite slave with NUM_REGS 32-bit read/write control
//             registers. Out-of-range accesses complete with SLVERR.
//  Ports    :
//    aclk, aresetn          clock, asynchronous active-low reset
//    axi_lite_s_aw*         write address channel
//    axi_lite_s_w*          write data channel (32-bit data, 4 strobes)
//    axi_lite_s_b*          write response channel
//    axi_lite_s_ar*         read address channel
//    axi_lite_s_r*          read data channel
//    reg_out                flattened register contents, reg i at [32*i +: 32]
//    reg_wr_pulse           one-cycle pulse per register after it is written
//  Revision : 1.0  initial release
// ============================================================================
module axil_ctrl_regfile
   import axil_regfile_pkg::*;
#(
   parameter int          AXI_ADDR_WIDTH = 32,
   parameter int          NUM_REGS       = 8,
   parameter logic [31:0] RESET_VALUE    = 32'h0
) (
   input  logic                      aclk,
   input  logic                      aresetn,
   input  logic [AXI_ADDR_WIDTH-1:0] axi_lite_s_awaddr,
   input  logic                      axi_lite_s_awvalid,
   output logic                      axi_lite_s_awready,
   input  logic [31:0]               axi_lite_s_wdata,
   input  logic [3:0]                axi_lite_s_wstrb,
   input  logic                      axi_lite_s_wvalid,
   output logic                      axi_lite_s_wready,
   output logic [1:0]                axi_lite_s_bresp,
   output logic                      axi_lite_s_bvalid,
   input  logic                      axi_lite_s_bready,
   input  logic [AXI_ADDR_WIDTH-1:0] axi_lite_s_araddr,
   input  logic                      axi_lite_s_arvalid,
   output logic                      axi_lite_s_arready,
   output logic [31:0]               axi_lite_s_rdata,
   output logic [1:0]                axi_lite_s_rresp,
   output logic                      axi_lite_s_rvalid,
   input  logic                      axi_lite_s_rready,
   output logic [NUM_REGS*32-1:0]    reg_out,
   output logic [NUM_REGS-1:0]       reg_wr_pulse
);

   localparam int c_IDX_W = AXI_ADDR_WIDTH - 2;
   localparam int c_SEL_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

   // Compare at 64 bits so any address width and register count fit.
   function automatic logic f_in_range(input logic [c_IDX_W-1:0] idx);
      return 64'(idx) < 64'(NUM_REGS);
   endfunction

   // ------------------------------------------------------------------
   // State and storage
   // ------------------------------------------------------------------
   wr_state_e            r_wr_state;
   wr_state_e            w_wr_state_nxt;
   rd_state_e            r_rd_state;
   rd_state_e            w_rd_state_nxt;

   logic                 r_aw_full;
   logic [c_IDX_W-1:0]   r_aw_idx;
   logic                 r_w_full;
   logic [31:0]          r_wdata;
   logic [3:0]           r_wstrb;
   logic [1:0]           r_bresp;

   logic [31:0]          r_rdata;
   logic [1:0]           r_rresp;

   logic [31:0]          r_regs [NUM_REGS];
   logic [NUM_REGS-1:0]  r_wr_pulse;

   // ------------------------------------------------------------------
   // Combinational decode
   // ------------------------------------------------------------------
   logic                 w_aw_hs;
   logic                 w_w_hs;
   logic                 w_ar_hs;
   logic                 w_commit;
   logic                 w_aw_in_range;
   logic [c_SEL_W-1:0]   w_aw_sel;
   logic [c_IDX_W-1:0]   w_ar_idx;
   logic                 w_ar_in_range;
   logic [c_SEL_W-1:0]   w_ar_sel;
   logic [31:0]          w_rd_word;
   logic [NUM_REGS-1:0]  w_wr_hit;

   // Byte-lane bits of the addresses do not take part in the decode.
   logic                 w_unused_addr_lsbs;
   assign w_unused_addr_lsbs = ^{axi_lite_s_awaddr[1:0], axi_lite_s_araddr[1:0]};

   assign axi_lite_s_awready = !r_aw_full && (r_wr_state == WR_IDLE);
   assign axi_lite_s_wready  = !r_w_full  && (r_wr_state == WR_IDLE);
   assign axi_lite_s_bvalid  = (r_wr_state == WR_RESP);
   assign axi_lite_s_bresp   = r_bresp;

   assign axi_lite_s_arready = (r_rd_state == RD_IDLE);
   assign axi_lite_s_rvalid  = (r_rd_state == RD_RESP);
   assign axi_lite_s_rdata   = r_rdata;
   assign axi_lite_s_rresp   = r_rresp;

   assign w_aw_hs = axi_lite_s_awvalid && axi_lite_s_awready;
   assign w_w_hs  = axi_lite_s_wvalid  && axi_lite_s_wready;
   assign w_ar_hs = axi_lite_s_arvalid && axi_lite_s_arready;

   assign w_aw_in_range = f_in_range(r_aw_idx);
   assign w_aw_sel      = r_aw_idx[c_SEL_W-1:0];

   assign w_ar_idx      = axi_lite_s_araddr[AXI_ADDR_WIDTH-1:2];
   assign w_ar_in_range = f_in_range(w_ar_idx);
   assign w_ar_sel      = w_ar_idx[c_SEL_W-1:0];

   // Per-register write enable; only ever one-hot on a committing edge.
   always_comb begin
      w_wr_hit = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         w_wr_hit[i] = w_commit && w_aw_in_range && (w_aw_sel == c_SEL_W'(i));
      end
   end

   // Read mux; out-of-range selects are masked when rdata is registered.
   always_comb begin
      w_rd_word = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (w_ar_sel == c_SEL_W'(i)) begin
            w_rd_word = r_regs[i];
         end
      end
   end

   // ------------------------------------------------------------------
   // Write path FSM
   // ------------------------------------------------------------------
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_wr_state <= WR_IDLE;
      end else begin
         r_wr_state <= w_wr_state_nxt;
      end
   end

   always_comb begin
      w_wr_state_nxt = r_wr_state;
      w_commit       = 1'b0;
      case (r_wr_state)
         WR_IDLE: begin
            if (r_aw_full && r_w_full) begin
               w_commit       = 1'b1;
               w_wr_state_nxt = WR_RESP;
            end
         end
         WR_RESP: begin
            if (axi_lite_s_bready) begin
               w_wr_state_nxt = WR_IDLE;
            end
         end
         default: w_wr_state_nxt = WR_IDLE;
      endcase
   end

   // AW and W holding registers fill independently; the commit drains both.
   // Ready is low while full, so a fill and a drain never coincide.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_aw_full <= 1'b0;
         r_aw_idx  <= '0;
         r_w_full  <= 1'b0;
         r_wdata   <= '0;
         r_wstrb   <= '0;
         r_bresp   <= RESP_OKAY;
      end else begin
         if (w_aw_hs) begin
            r_aw_full <= 1'b1;
            r_aw_idx  <= axi_lite_s_awaddr[AXI_ADDR_WIDTH-1:2];
         end else if (w_commit) begin
            r_aw_full <= 1'b0;
         end
         if (w_w_hs) begin
            r_w_full <= 1'b1;
            r_wdata  <= axi_lite_s_wdata;
            r_wstrb  <= axi_lite_s_wstrb;
         end else if (w_commit) begin
            r_w_full <= 1'b0;
         end
         if (w_commit) begin
            r_bresp <= w_aw_in_range ? RESP_OKAY : RESP_SLVERR;
         end
      end
   end

   // Register array and write pulses.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_regs[i] <= RESET_VALUE;
         end
         r_wr_pulse <= '0;
      end else begin
         r_wr_pulse <= w_wr_hit;
         for (int i = 0; i < NUM_REGS; i++) begin
            if (w_wr_hit[i]) begin
               r_regs[i] <= apply_wstrb(r_regs[i], r_wdata, r_wstrb);
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Read path FSM
   // ------------------------------------------------------------------
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_rd_state <= RD_IDLE;
      end else begin
         r_rd_state <= w_rd_state_nxt;
      end
   end

   always_comb begin
      w_rd_state_nxt = r_rd_state;
      case (r_rd_state)
         RD_IDLE: begin
            if (axi_lite_s_arvalid) begin
               w_rd_state_nxt = RD_RESP;
            end
         end
         RD_RESP: begin
            if (axi_lite_s_rready) begin
               w_rd_state_nxt = RD_IDLE;
            end
         end
         default: w_rd_state_nxt = RD_IDLE;
      endcase
   end

   // Sampled from r_regs before any same-edge commit lands, so a read that
   // coincides with a write returns the pre-write value.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_rdata <= '0;
         r_rresp <= RESP_OKAY;
      end else if (w_ar_hs) begin
         r_rdata <= w_ar_in_range ? w_rd_word : 32'h0;
         r_rresp <= w_ar_in_range ? RESP_OKAY : RESP_SLVERR;
      end
   end

   // ------------------------------------------------------------------
   // Control outputs
   // ------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg_out
         assign reg_out[32*gi +: 32] = r_regs[gi];
      end
   endgenerate

   assign reg_wr_pulse = r_wr_pulse;

endmodule
`default_nettype wire

// File: tb/tb_axil_ctrl_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axil_ctrl_regfile
//  Purpose  : Self-checking bench for axil_ctrl_regfile. Directed scenarios
//             followed by random single-outstanding traffic; responses are
//             checked by a monitor against queues filled at issue time.
//  Revision : 1.0  initial release
// ============================================================================
module tb_axil_ctrl_regfile;

   localparam int NR = 8;

   logic               aclk = 1'b0;
   logic               aresetn;
   logic [31:0]        awaddr;
   logic               awvalid;
   logic               awready;
   logic [31:0]        wdata;
   logic [3:0]         wstrb;
   logic               wvalid;
   logic               wready;
   logic [1:0]         bresp;
   logic               bvalid;
   logic               bready;
   logic [31:0]        araddr;
   logic               arvalid;
   logic               arready;
   logic [31:0]        rdata;
   logic [1:0]         rresp;
   logic               rvalid;
   logic               rready;
   logic [NR*32-1:0]   reg_out;
   logic [NR-1:0]      reg_wr_pulse;

   always #5 aclk = ~aclk;

   axil_ctrl_regfile #(
      .AXI_ADDR_WIDTH (32),
      .NUM_REGS       (NR),
      .RESET_VALUE    (32'h0)
   ) dut (
      .aclk               (aclk),
      .aresetn            (aresetn),
      .axi_lite_s_awaddr  (awaddr),
      .axi_lite_s_awvalid (awvalid),
      .axi_lite_s_awready (awready),
      .axi_lite_s_wdata   (wdata),
      .axi_lite_s_wstrb   (wstrb),
      .axi_lite_s_wvalid  (wvalid),
      .axi_lite_s_wready  (wready),
      .axi_lite_s_bresp   (bresp),
      .axi_lite_s_bvalid  (bvalid),
      .axi_lite_s_bready  (bready),
      .axi_lite_s_araddr  (araddr),
      .axi_lite_s_arvalid (arvalid),
      .axi_lite_s_arready (arready),
      .axi_lite_s_rdata   (rdata),
      .axi_lite_s_rresp   (rresp),
      .axi_lite_s_rvalid  (rvalid),
      .axi_lite_s_rready  (rready),
      .reg_out            (reg_out),
      .reg_wr_pulse       (reg_wr_pulse)
   );

   // ------------------------------------------------------------------
   // Counters, reference model and scoreboard queues
   // ------------------------------------------------------------------
   int total = 0;
   int bad   = 0;
   int b_seen = 0;
   int r_seen = 0;
   int b_exp  = 0;
   int r_exp  = 0;
   bit hold_b = 1'b0;
   bit hold_r = 1'b0;

   logic [31:0]    m_regs [NR];
   logic [1:0]     q_bresp [$];
   logic [255:0]   q_bregs [$];
   logic [31:0]    q_rdata [$];
   logic [1:0]     q_rresp [$];
   logic [NR-1:0]  q_pulse [$];

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [255:0] model_flat();
      logic [255:0] f;
      f = '0;
      for (int i = 0; i < NR; i++) f[32*i +: 32] = m_regs[i];
      return f;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NR; i++) m_regs[i] = 32'h0;
   endtask

   // Expected outcome of a write, derived from the address/strobe rules.
   task automatic push_write_exp(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      longint unsigned idx;
      int ii;
      idx = longint'(a >> 2);
      if (idx < NR) begin
         ii = int'(idx);
         for (int b = 0; b < 4; b++)
            if (s[b]) m_regs[ii][8*b +: 8] = d[8*b +: 8];
         q_pulse.push_back(NR'(1) << ii);
         q_bresp.push_back(2'b00);
      end else begin
         q_bresp.push_back(2'b10);
      end
      q_bregs.push_back(model_flat());
      b_exp++;
   endtask

   task automatic push_read_exp(input logic [31:0] a);
      longint unsigned idx;
      idx = longint'(a >> 2);
      if (idx < NR) begin
         q_rdata.push_back(m_regs[int'(idx)]);
         q_rresp.push_back(2'b00);
      end else begin
         q_rdata.push_back(32'h0);
         q_rresp.push_back(2'b10);
      end
      r_exp++;
   endtask

   // ------------------------------------------------------------------
   // Monitor: checks every response handshake against the queues
   // ------------------------------------------------------------------
   always @(negedge aclk) begin
      if (aresetn === 1'b1) begin
         if (bvalid && bready) begin
            if (q_bresp.size() == 0) begin
               total++; bad++;
               $display("FAIL b_unexpected: got bresp %0h expected no response", bresp);
            end else begin
               check("bresp", bresp, q_bresp.pop_front());
               check("reg_out_at_b", reg_out, q_bregs.pop_front());
            end
            b_seen++;
         end
         if (rvalid && rready) begin
            if (q_rdata.size() == 0) begin
               total++; bad++;
               $display("FAIL r_unexpected: got rdata %0h expected no response", rdata);
            end else begin
               check("rdata", rdata, q_rdata.pop_front());
               check("rresp", rresp, q_rresp.pop_front());
            end
            r_seen++;
         end
         if (reg_wr_pulse != '0) begin
            if (q_pulse.size() == 0) begin
               total++; bad++;
               $display("FAIL pulse_unexpected: got %0h expected 0", reg_wr_pulse);
            end else begin
               check("reg_wr_pulse", reg_wr_pulse, q_pulse.pop_front());
            end
         end
      end
   end

   // Random back-pressure on B and R unless a scenario holds it low.
   initial begin
      bready = 1'b0;
      rready = 1'b0;
      forever begin
         @(posedge aclk); #1;
         bready = hold_b ? 1'b0 : ($urandom % 3 != 0);
         rready = hold_r ? 1'b0 : ($urandom % 3 != 0);
      end
   end

   // ------------------------------------------------------------------
   // Channel drivers (called and return at posedge + 1)
   // ------------------------------------------------------------------
   task automatic send_aw(input logic [31:0] a, input int dly);
      bit done;
      done = 1'b0;
      repeat (dly) begin @(posedge aclk); #1; end
      awaddr = a; awvalid = 1'b1;
      for (int n = 0; n < 100 && !done; n++) begin
         @(negedge aclk);
         if (awready) begin @(posedge aclk); #1; done = 1'b1; end
      end
      awvalid = 1'b0;
      if (!done) begin total++; bad++; $display("FAIL aw_timeout: awready low for 100 cycles, expected acceptance"); end
   endtask

   task automatic send_w(input logic [31:0] d, input logic [3:0] s, input int dly);
      bit done;
      done = 1'b0;
      repeat (dly) begin @(posedge aclk); #1; end
      wdata = d; wstrb = s; wvalid = 1'b1;
      for (int n = 0; n < 100 && !done; n++) begin
         @(negedge aclk);
         if (wready) begin @(posedge aclk); #1; done = 1'b1; end
      end
      wvalid = 1'b0;
      if (!done) begin total++; bad++; $display("FAIL w_timeout: wready low for 100 cycles, expected acceptance"); end
   endtask

   task automatic send_ar(input logic [31:0] a);
      bit done;
      done = 1'b0;
      araddr = a; arvalid = 1'b1;
      for (int n = 0; n < 100 && !done; n++) begin
         @(negedge aclk);
         if (arready) begin @(posedge aclk); #1; done = 1'b1; end
      end
      arvalid = 1'b0;
      if (!done) begin total++; bad++; $display("FAIL ar_timeout: arready low for 100 cycles, expected acceptance"); end
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly);
      push_write_exp(a, d, s);
      fork
         send_aw(a, aw_dly);
         send_w(d, s, w_dly);
      join
   endtask

   task automatic do_read(input logic [31:0] a);
      push_read_exp(a);
      send_ar(a);
   endtask

   task automatic wait_b();
      int n;
      n = 0;
      while (b_seen < b_exp && n < 300) begin @(posedge aclk); n++; end
      if (b_seen < b_exp) begin total++; bad++; $display("FAIL b_timeout: got %0d responses expected %0d", b_seen, b_exp); end
      @(posedge aclk); #1;
   endtask

   task automatic wait_r();
      int n;
      n = 0;
      while (r_seen < r_exp && n < 300) begin @(posedge aclk); n++; end
      if (r_seen < r_exp) begin total++; bad++; $display("FAIL r_timeout: got %0d responses expected %0d", r_seen, r_exp); end
      @(posedge aclk); #1;
   endtask

   // ------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------
   initial begin
      aresetn = 1'b0;
      awaddr = '0; awvalid = 1'b0;
      wdata = '0; wstrb = '0; wvalid = 1'b0;
      araddr = '0; arvalid = 1'b0;
      model_reset();

      // Reset state
      repeat (3) @(posedge aclk);
      #1;
      check("rst_bvalid", bvalid, 1'b0);
      check("rst_rvalid", rvalid, 1'b0);
      check("rst_reg_out", reg_out, '0);
      check("rst_pulse", reg_wr_pulse, '0);
      check("rst_rdata", rdata, 32'h0);
      aresetn = 1'b1;
      @(posedge aclk); #1;
      check("rst_awready", awready, 1'b1);
      check("rst_wready", wready, 1'b1);
      check("rst_arready", arready, 1'b1);
      for (int i = 0; i < NR; i++) begin
         do_read(32'(4 * i));
         wait_r();
      end

      // Same-cycle AW/W to reg 2: bvalid one edge after acceptance
      do_write(32'h08, 32'hDEADBEEF, 4'hF, 0, 0);
      check("lat_bvalid_early", bvalid, 1'b0);
      @(posedge aclk); #1;
      check("lat_bvalid", bvalid, 1'b1);
      check("lat_reg2", reg_out[95:64], 32'hDEADBEEF);
      check("lat_pulse", reg_wr_pulse, 8'b0000_0100);
      wait_b();
      do_read(32'h08);
      wait_r();

      // W three cycles ahead of AW, partial strobes, B held off
      do_write(32'h0C, 32'hAAAAAAAA, 4'hF, 0, 0);
      wait_b();
      hold_b = 1'b1; bready = 1'b0;
      do_write(32'h0C, 32'h11223344, 4'b0101, 3, 0);
      @(posedge aclk); #1;
      for (int c = 0; c < 5; c++) begin
         check("hold_bvalid", bvalid, 1'b1);
         check("hold_awready", awready, 1'b0);
         check("hold_wready", wready, 1'b0);
         @(posedge aclk); #1;
      end
      check("strb_reg3", reg_out[127:96], 32'hAA22AA44);
      hold_b = 1'b0;
      wait_b();

      // Out-of-range write and read
      do_write(32'h20, 32'h12345678, 4'hF, 0, 1);
      wait_b();
      do_read(32'h24);
      wait_r();

      // Read of reg 1 accepted on the commit edge of a write to reg 1
      do_write(32'h04, 32'hCAFE0001, 4'hF, 0, 0);
      wait_b();
      push_read_exp(32'h04);
      push_write_exp(32'h04, 32'h5, 4'hF);
      check("coll_awready", awready, 1'b1);
      awaddr = 32'h04; awvalid = 1'b1;
      wdata = 32'h5; wstrb = 4'hF; wvalid = 1'b1;
      @(posedge aclk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      check("coll_arready", arready, 1'b1);
      araddr = 32'h04; arvalid = 1'b1;
      @(posedge aclk); #1;
      arvalid = 1'b0;
      wait_b();
      wait_r();
      do_read(32'h04);
      wait_r();

      // Reset with AW held and a read response pending
      hold_r = 1'b1; rready = 1'b0;
      send_aw(32'h08, 0);
      send_ar(32'h08);
      @(posedge aclk); #1;
      check("pre_rst_rvalid", rvalid, 1'b1);
      check("pre_rst_awready", awready, 1'b0);
      #2 aresetn = 1'b0;
      #1;
      model_reset();
      check("mid_rst_rvalid", rvalid, 1'b0);
      check("mid_rst_bvalid", bvalid, 1'b0);
      check("mid_rst_reg_out", reg_out, '0);
      check("mid_rst_awready", awready, 1'b1);
      check("mid_rst_arready", arready, 1'b1);
      repeat (2) @(posedge aclk);
      #1 aresetn = 1'b1;
      hold_r = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(posedge aclk); #1;
         check("no_stale_b", bvalid, 1'b0);
         check("no_stale_r", rvalid, 1'b0);
      end
      do_write(32'h10, 32'h600DF00D, 4'hF, 2, 0);
      wait_b();
      do_read(32'h08);
      wait_r();
      do_read(32'h10);
      wait_r();

      // Random traffic
      for (int k = 0; k < 150; k++) begin
         logic [31:0] a;
         a = {26'h0, 4'($urandom_range(0, 11)), 2'($urandom)};
         if ($urandom % 10 == 0) a[31] = 1'b1;
         if ($urandom % 2 == 0) begin
            do_write(a, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
            wait_b();
         end else begin
            do_read(a);
            wait_r();
         end
      end

      repeat (4) @(posedge aclk);
      #1;
      check("end_q_b", 32'(q_bresp.size()), 32'h0);
      check("end_q_r", 32'(q_rdata.size()), 32'h0);
      check("end_q_pulse", 32'(q_pulse.size()), 32'h0);
      check("end_reg_out", reg_out, model_flat());

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire

// File: doc/axil_ctrl_regfile.md
Name: axil_ctrl_regfile

Overview:
AXI-Lite slave endpoint holding NUM_REGS 32-bit read/write control registers. It connects directly to the master side of the AXI-Lite register slice and terminates all five channels. Register contents drive control outputs into the rest of the design, with a one-cycle write strobe per register. Out-of-range accesses complete with SLVERR, so the bus never hangs.

Parameters:
AXI_ADDR_WIDTH, 32, width of awaddr/araddr.
NUM_REGS, 8, number of 32-bit registers (1..256); register i sits at byte offset 4*i.
RESET_VALUE, 32'h0, reset value applied to every register.

Ports:
aclk  in  1  clock; all interfaces synchronous to it.
aresetn  in  1  asynchronous active-low reset.
axi_lite_s_awaddr  in  AXI_ADDR_WIDTH  write address.
axi_lite_s_awvalid  in  1  write address valid.
axi_lite_s_awready  out  1  write address ready.
axi_lite_s_wdata  in  32  write data.
axi_lite_s_wstrb  in  4  byte strobes.
axi_lite_s_wvalid  in  1  write data valid.
axi_lite_s_wready  out  1  write data ready.
axi_lite_s_bresp  out  2  write response (00 OKAY, 10 SLVERR).
axi_lite_s_bvalid  out  1  write response valid.
axi_lite_s_bready  in  1  write response ready.
axi_lite_s_araddr  in  AXI_ADDR_WIDTH  read address.
axi_lite_s_arvalid  in  1  read address valid.
axi_lite_s_arready  out  1  read address ready.
axi_lite_s_rdata  out  32  read data.
axi_lite_s_rresp  out  2  read response.
axi_lite_s_rvalid  out  1  read data valid.
axi_lite_s_rready  in  1  read data ready.
reg_out  out  NUM_REGS*32  flattened register contents; register i at bits [32*i +: 32].
reg_wr_pulse  out  NUM_REGS  one-cycle pulse on the cycle after register i is written.

Behaviour:
- Reset (async assert, released synchronously to aclk):
  - all registers = RESET_VALUE
  - bvalid = rvalid = 0; bresp = rresp = 00; rdata = 0
  - reg_wr_pulse = 0; internal aw_full = w_full = 0
  - awready, wready and arready go to 1 after reset.
- Address decode: idx = addr[AXI_ADDR_WIDTH-1:2]. In range iff idx < NUM_REGS. addr[1:0] is ignored.
- Write channels:
  - awready = !aw_full && !bvalid; wready = !w_full && !bvalid.
  - AW and W are captured independently into holding registers, in either order or on the same cycle.
  - A commit occurs on the first edge where aw_full && w_full && !bvalid.
    - In range: each byte b with wstrb[b]=1 is written; bresp = 00; reg_wr_pulse[idx] = 1 for exactly one cycle.
    - Out of range: no register changes; bresp = 10.
    - On both outcomes, bvalid is set and aw_full and w_full are cleared.
  - bvalid and bresp stay stable until bready; bvalid clears on the handshake edge.
  - Latency: AW+W accepted at edge 0 → commit at edge 1 → bvalid and reg_out updated after edge 1. The earliest next AW/W acceptance is the edge after the B handshake.
  - wstrb = 0 in range: OKAY response, no data change, reg_wr_pulse still fires.
- Read channel:
  - arready = !rvalid.
  - On the AR handshake edge, rdata and rresp are registered: register value/00 in range, 0/10 out of range. rvalid is set.
  - rvalid, rdata and rresp stay stable until rready; rvalid clears on the handshake edge.
  - Throughput: one read per two cycles.
- Read/write independence: both paths proceed concurrently. A read accepted on the same edge as a commit to the same register returns the pre-write value.
- Mid-transaction reset: held AW/W and pending B/R are discarded, with no partial register update.
- reg_out is a direct register output with no combinational path from the bus inputs.

Decomposition:
- Package axil_regfile_pkg holds:
  - localparams RESP_OKAY = 2'b00 and RESP_SLVERR = 2'b10
  - function apply_wstrb(old, wdata, wstrb), returning the byte-merged 32-bit word.
- No sub-module: the write and read paths are each small FSMs in a single module.

Test Plan:
- Reset with NUM_REGS=8: read all 8 → rdata 0, rresp 00; write handshakes not blocked (awready=wready=1).
- AW 0x08 and W 0xDEADBEEF/strb F on the same cycle → bvalid after 1 cycle, bresp 00, reg_out[95:64]=0xDEADBEEF, reg_wr_pulse=8'b00000100 for one cycle; read 0x08 returns 0xDEADBEEF.
- W 0x11223344/strb 0101 three cycles before AW 0x0C, onto a reg preset to 0xAAAAAAAA → reg 3 = 0xAA22AA44; awready/wready low while bvalid is held with bready=0 for 5 cycles.
- Write 0x20 and read 0x24 (out of range) → bresp 10, rresp 10, rdata 0; no reg_out change and no reg_wr_pulse.
- Read of reg 1 accepted on the same edge as a commit of 0x5 to reg 1 → rdata is the old value; a following read returns 0x5.
- aresetn dropped while AW is held and rvalid=1 → outputs reset immediately; after release, new write completes normally and no stale B/R is issued.
